hazard_stall_unit: RTL and testbench

- Producer-side partner to the forwarding select logic in the 5-stage MIPS pipeline.
- Tracks each in-flight destination register and its remaining Tnew through the E/M/W stages, and compares it against the Tuse of the instruction in D.
- Drives the pipeline freeze/bubble controls.
- Also owns the mult/div busy counter and stalls HI/LO-using instructions in D while the unit is busy.
- Exports per-stage A3/Tnew so the forwarding select logic reads stage state from one place.

---
 rtl/hazard_stall_unit_pkg.sv | 29 ++
 rtl/hazard_stall_unit_if.sv | 35 +++
 rtl/hazard_stall_unit_md_busy_counter.sv | 34 +++
 rtl/hazard_stall_unit.sv | 86 ++++++++
 tb/tb_hazard_stall_unit.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_stall_unit_pkg.sv
// Shared codes and helpers for the pipeline hazard/stall unit.
// Tnew/Tuse encodings match the decoder's stage-timing fields.
package hazard_stall_unit_pkg;

    localparam logic [1:0] PC_T      = 2'd0;
    localparam logic [1:0] ALU_T     = 2'd1;
    localparam logic [1:0] DM_T      = 2'd2;
    localparam logic [1:0] TUSE_NONE = 2'd3;

    localparam int unsigned MULT_CYC_DEF = 5;
    localparam int unsigned DIV_CYC_DEF  = 10;
    localparam int unsigned CNT_W_DEF    = 4;

    typedef struct packed {
        logic [4:0] a3;
        logic [1:0] tnew;
    } stage_t;

    function automatic logic [1:0] sat0_dec(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

    // $0 never matches; a tnew that exceeds tuse means the value arrives too late to forward.
    function automatic logic hz_match(input logic [4:0] x, input logic [4:0] a3,
                                      input logic [1:0] tnew, input logic [1:0] tuse);
        return (x != 5'd0) && (x == a3) && (tnew > tuse);
    endfunction

endpackage

// File: rtl/hazard_stall_unit_if.sv
// Decoded D-stage fields in, stall controls and per-stage destination state out.
interface hazard_stall_unit_if;

    logic [4:0] rs_D;
    logic [4:0] rt_D;
    logic [1:0] tuse_rs_D;
    logic [1:0] tuse_rt_D;
    logic [4:0] a3_D;
    logic [1:0] tnew_D;
    logic       md_use_D;
    logic       md_start_D;
    logic       md_div_D;

    logic       stall;
    logic       pc_en;
    logic       d_en;
    logic       e_clr;
    logic [4:0] a3_E;
    logic [4:0] a3_M;
    logic [4:0] a3_W;
    logic [1:0] tnew_E;
    logic [1:0] tnew_M;
    logic       md_busy;

    modport master (
        output rs_D, rt_D, tuse_rs_D, tuse_rt_D, a3_D, tnew_D, md_use_D, md_start_D, md_div_D,
        input  stall, pc_en, d_en, e_clr, a3_E, a3_M, a3_W, tnew_E, tnew_M, md_busy
    );

    modport slave (
        input  rs_D, rt_D, tuse_rs_D, tuse_rt_D, a3_D, tnew_D, md_use_D, md_start_D, md_div_D,
        output stall, pc_en, d_en, e_clr, a3_E, a3_M, a3_W, tnew_E, tnew_M, md_busy
    );

endinterface

// File: rtl/hazard_stall_unit_md_busy_counter.sv
// Mult/div busy counter: loads the operation latency, counts down, flags busy while nonzero.
module hazard_stall_unit_md_busy_counter #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             busy
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_stall_unit.sv
// Tracks in-flight destinations/Tnew through E/M/W and stalls D on Tuse conflicts
// or HI/LO access while the mult/div unit is busy.
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int unsigned MULT_CYC = MULT_CYC_DEF,
    parameter int unsigned DIV_CYC  = DIV_CYC_DEF,
    parameter int unsigned CNT_W    = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    hazard_stall_unit_if.slave hz
);

    localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYC);
    localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYC);

    stage_t     e_q;
    stage_t     e_d;
    stage_t     m_q;
    stage_t     m_d;
    logic [4:0] w_q;

    logic             stall;
    logic             md_busy;
    logic             md_load;
    logic [CNT_W-1:0] md_load_val;

    // W always has Tnew = 0, so it can always forward and never stalls.
    always_comb begin
        stall = hz_match(hz.rs_D, e_q.a3, e_q.tnew, hz.tuse_rs_D)
              | hz_match(hz.rt_D, e_q.a3, e_q.tnew, hz.tuse_rt_D)
              | hz_match(hz.rs_D, m_q.a3, m_q.tnew, hz.tuse_rs_D)
              | hz_match(hz.rt_D, m_q.a3, m_q.tnew, hz.tuse_rt_D)
              | (hz.md_use_D & md_busy);
    end

    always_comb begin
        m_d.a3   = e_q.a3;
        m_d.tnew = sat0_dec(e_q.tnew);
        if (stall) begin
            e_d.a3   = 5'd0;
            e_d.tnew = PC_T;
        end else begin
            e_d.a3   = hz.a3_D;
            e_d.tnew = hz.tnew_D;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= 5'd0;
        end else begin
            e_q <= e_d;
            m_q <= m_d;
            w_q <= m_q.a3;
        end
    end

    assign md_load     = ~stall & hz.md_start_D;
    assign md_load_val = hz.md_div_D ? DIV_LD : MULT_LD;

    hazard_stall_unit_md_busy_counter #(
        .CNT_W (CNT_W)
    ) u_md_busy_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (md_load),
        .load_val (md_load_val),
        .busy     (md_busy)
    );

    assign hz.stall   = stall;
    assign hz.pc_en   = ~stall;
    assign hz.d_en    = ~stall;
    assign hz.e_clr   = stall;
    assign hz.a3_E    = e_q.a3;
    assign hz.a3_M    = m_q.a3;
    assign hz.a3_W    = w_q;
    assign hz.tnew_E  = e_q.tnew;
    assign hz.tnew_M  = m_q.tnew;
    assign hz.md_busy = md_busy;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: per-cycle compare against an age-based pipeline model
// plus literal expectations for the classic hazard scenarios.
module tb_hazard_stall_unit;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    hazard_stall_unit_if hz();

    hazard_stall_unit #(
        .MULT_CYC (MULT_N),
        .DIV_CYC  (DIV_N),
        .CNT_W    (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    int vectors = 0;
    int miscompares = 0;

    // Model: each stage holds the instruction's destination and its Tnew at E entry;
    // remaining Tnew is derived from how many stages it has advanced.
    logic [4:0] m_a3 [3];
    int         m_t0 [3];
    int         cyc;
    int         md_end;

    function automatic int m_rem(input int s);
        return (m_t0[s] > s) ? m_t0[s] - s : 0;
    endfunction

    function automatic logic m_busy();
        return cyc < md_end;
    endfunction

    function automatic logic m_stall();
        logic s;
        s = 1'b0;
        for (int st = 0; st < 2; st++) begin
            if (hz.rs_D != 0 && hz.rs_D == m_a3[st] && m_rem(st) > int'(hz.tuse_rs_D)) s = 1'b1;
            if (hz.rt_D != 0 && hz.rt_D == m_a3[st] && m_rem(st) > int'(hz.tuse_rt_D)) s = 1'b1;
        end
        if (hz.md_use_D && m_busy()) s = 1'b1;
        return s;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                m_a3[i] <= '0;
                m_t0[i] <= 0;
            end
            cyc    <= 0;
            md_end <= 0;
        end else begin
            m_a3[2] <= m_a3[1];
            m_t0[2] <= m_t0[1];
            m_a3[1] <= m_a3[0];
            m_t0[1] <= m_t0[0];
            m_a3[0] <= m_stall() ? 5'd0 : hz.a3_D;
            m_t0[0] <= m_stall() ? 0 : int'(hz.tnew_D);
            cyc     <= cyc + 1;
            if (!m_stall() && hz.md_start_D) md_end <= cyc + 1 + (hz.md_div_D ? DIV_N : MULT_N);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        check("stall", int'(hz.stall), int'(m_stall()));
        check("pc_en", int'(hz.pc_en), int'(!m_stall()));
        check("d_en", int'(hz.d_en), int'(!m_stall()));
        check("e_clr", int'(hz.e_clr), int'(m_stall()));
        check("a3_E", int'(hz.a3_E), int'(m_a3[0]));
        check("a3_M", int'(hz.a3_M), int'(m_a3[1]));
        check("a3_W", int'(hz.a3_W), int'(m_a3[2]));
        check("tnew_E", int'(hz.tnew_E), m_rem(0));
        check("tnew_M", int'(hz.tnew_M), m_rem(1));
        check("md_busy", int'(hz.md_busy), int'(m_busy()));
    end

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [1:0] tu_rs,
                         input logic [1:0] tu_rt, input logic [4:0] a3, input logic [1:0] tn,
                         input logic mdu, input logic mds, input logic mdd);
        hz.rs_D       = rs;
        hz.rt_D       = rt;
        hz.tuse_rs_D  = tu_rs;
        hz.tuse_rt_D  = tu_rt;
        hz.a3_D       = a3;
        hz.tnew_D     = tn;
        hz.md_use_D   = mdu;
        hz.md_start_D = mds;
        hz.md_div_D   = mdd;
        #1;
    endtask

    task automatic nop();
        drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int busy_cnt;
        nop();
        repeat (2) @(posedge clk);
        #1;
        check("rst_stall", int'(hz.stall), 0);
        check("rst_pc_en", int'(hz.pc_en), 1);
        check("rst_md_busy", int'(hz.md_busy), 0);
        reset = 1'b0;

        // Load-use: lw $8 then add using $8 as rs.
        drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd8, 2'd2, 1'b0, 1'b0, 1'b0);
        step();
        drive(5'd8, 5'd0, 2'd1, 2'd3, 5'd10, 2'd1, 1'b0, 1'b0, 1'b0);
        check("lu_stall", int'(hz.stall), 1);
        check("lu_e_clr", int'(hz.e_clr), 1);
        check("lu_tnew_E", int'(hz.tnew_E), 2);
        step();
        check("lu_a3_M", int'(hz.a3_M), 8);
        check("lu_tnew_M", int'(hz.tnew_M), 1);
        check("lu_bubble", int'(hz.a3_E), 0);
        check("lu_release", int'(hz.stall), 0);
        step();
        check("lu_a3_W", int'(hz.a3_W), 8);
        check("lu_a3_E", int'(hz.a3_E), 10);

        // Branch after ALU producer.
        drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd9, 2'd1, 1'b0, 1'b0, 1'b0);
        step();
        drive(5'd0, 5'd9, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        check("br_stall", int'(hz.stall), 1);
        step();
        check("br_tnew_M", int'(hz.tnew_M), 0);
        check("br_release", int'(hz.stall), 0);
        step();

        // Branch after load: stalls in E and again in M.
        drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd7, 2'd2, 1'b0, 1'b0, 1'b0);
        step();
        drive(5'd7, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        check("bl_stall_E", int'(hz.stall), 1);
        step();
        check("bl_stall_M", int'(hz.stall), 1);
        step();
        check("bl_release", int'(hz.stall), 0);
        check("bl_a3_W", int'(hz.a3_W), 7);
        step();

        // Store data after load: tuse 2 tolerates tnew 2.
        drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd5, 2'd2, 1'b0, 1'b0, 1'b0);
        step();
        drive(5'd0, 5'd5, 2'd3, 2'd2, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        check("sw_no_stall", int'(hz.stall), 0);
        step();

        // $0 immunity.
        drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd2, 1'b0, 1'b0, 1'b0);
        step();
        drive(5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        check("zero_no_stall", int'(hz.stall), 0);
        step();

        // Div busy window, mflo held in D.
        drive(5'd0, 5'd0, 2'd1, 2'd1, 5'd0, 2'd0, 1'b1, 1'b1, 1'b1);
        step();
        drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd3, 2'd1, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= DIV_N; i++) begin
            check("div_busy", int'(hz.md_busy), 1);
            check("mflo_stall", int'(hz.stall), 1);
            step();
        end
        check("div_done", int'(hz.md_busy), 0);
        check("mflo_release", int'(hz.stall), 0);
        step();

        // Mult busy length.
        drive(5'd0, 5'd0, 2'd1, 2'd1, 5'd0, 2'd0, 1'b1, 1'b1, 1'b0);
        step();
        nop();
        busy_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (hz.md_busy) busy_cnt++;
            step();
        end
        check("mult_busy_cycles", busy_cnt, MULT_N);

        // Async reset in the middle of a load-use stall.
        drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd4, 2'd1, 1'b0, 1'b0, 1'b0);
        step();
        drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd8, 2'd2, 1'b0, 1'b0, 1'b0);
        step();
        drive(5'd8, 5'd0, 2'd1, 2'd3, 5'd10, 2'd1, 1'b0, 1'b0, 1'b0);
        check("ar_pre_stall", int'(hz.stall), 1);
        #1 reset = 1'b1;
        #1;
        check("ar_stall", int'(hz.stall), 0);
        check("ar_pc_en", int'(hz.pc_en), 1);
        check("ar_a3_E", int'(hz.a3_E), 0);
        check("ar_tnew_E", int'(hz.tnew_E), 0);
        check("ar_a3_M", int'(hz.a3_M), 0);
        step();
        reset = 1'b0;
        #1;
        check("ar_after_stall", int'(hz.stall), 0);
        step();
        check("ar_add_in_E", int'(hz.a3_E), 10);
        nop();
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
